totient_display_checker: RTL and testbench

TOTIENT_DISPLAY_CHECKER -- requirements
Module: totient_display_checker

---
 rtl/totient_display_checker.sv | 159 +++++++++++++++
 tb/tb_totient_display_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/totient_display_checker.sv
// Checks a 7-segment stream against the repeating totient sequence phi(n+1), n = 0..15.
// Build option: define TOTIENT_CHK_STICKY_FAULT_EN to make FAULT hold until reset.
module totient_display_checker (
    input  logic       CLK_LABEL,
    input  logic       R,
    input  logic [6:0] SEG,
    output logic [3:0] VALUE,
    output logic       GLYPH_OK,
    output logic       LOCKED,
    output logic       MISMATCH,
    output logic [7:0] ERR_CNT,
    output logic [3:0] IDX
);

    typedef enum logic [1:0] {StHunt, StLocked, StFault} state_e;

    state_e      state_q, state_d;
    logic [3:0]  value_q;
    logic        glyph_ok_q;
    logic        mismatch_q, mismatch_d;
    logic [7:0]  err_q, err_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  miss_q, miss_d;
    logic [3:0]  prev_val_q;
    logic        prev_ok_q;

    logic [3:0]  dec_val;
    logic        dec_ok;
    logic [3:0]  exp_val;
    logic        hit;

    function automatic logic [3:0] totient(input logic [3:0] n);
        logic [3:0] t;
        case (n)
            4'd0:    t = 4'h1;
            4'd1:    t = 4'h1;
            4'd2:    t = 4'h2;
            4'd3:    t = 4'h2;
            4'd4:    t = 4'h4;
            4'd5:    t = 4'h2;
            4'd6:    t = 4'h6;
            4'd7:    t = 4'h4;
            4'd8:    t = 4'h6;
            4'd9:    t = 4'h4;
            4'd10:   t = 4'hA;
            4'd11:   t = 4'h4;
            4'd12:   t = 4'hC;
            4'd13:   t = 4'h6;
            4'd14:   t = 4'h8;
            default: t = 4'h8;
        endcase
        return t;
    endfunction

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (SEG)
            7'b1111110: dec_val = 4'h0;
            7'b0110000: dec_val = 4'h1;
            7'b1101101: dec_val = 4'h2;
            7'b1111001: dec_val = 4'h3;
            7'b0110011: dec_val = 4'h4;
            7'b1011011: dec_val = 4'h5;
            7'b1011111: dec_val = 4'h6;
            7'b1110000: dec_val = 4'h7;
            7'b1111111: dec_val = 4'h8;
            7'b1111011: dec_val = 4'h9;
            7'b1110111: dec_val = 4'hA;
            7'b0011111: dec_val = 4'hB;
            7'b1001110: dec_val = 4'hC;
            7'b0111101: dec_val = 4'hD;
            7'b1001111: dec_val = 4'hE;
            7'b1000111: dec_val = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // The sample on this edge is compared against the position after the last matched one.
    assign exp_val = totient(idx_q + 4'd1);
    assign hit     = dec_ok && (dec_val == exp_val);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        miss_d     = miss_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        case (state_q)
            StHunt: begin
                // Only the 8 -> 1 pair (end of sequence wrapping to start) identifies phase.
                if (prev_ok_q && (prev_val_q == 4'h8) && dec_ok && (dec_val == 4'h1)) begin
                    state_d = StLocked;
                    idx_d   = 4'd0;
                    miss_d  = 2'd0;
                end
            end
            StLocked: begin
                idx_d = idx_q + 4'd1;
                if (hit) begin
                    miss_d = 2'd0;
                end else begin
                    mismatch_d = 1'b1;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    miss_d = miss_q + 2'd1;
                    if (miss_q == 2'd2) begin
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
`ifdef TOTIENT_CHK_STICKY_FAULT_EN
                state_d = StFault;
`else
                state_d = StHunt;
                miss_d  = 2'd0;
`endif
            end
            default: begin
                state_d = StHunt;
                miss_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK_LABEL) begin
        if (R) begin
            state_q    <= StHunt;
            value_q    <= 4'h0;
            glyph_ok_q <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= 8'h00;
            idx_q      <= 4'd0;
            miss_q     <= 2'd0;
            prev_val_q <= 4'h0;
            prev_ok_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            value_q    <= dec_ok ? dec_val : 4'h0;
            glyph_ok_q <= dec_ok;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            miss_q     <= miss_d;
            prev_val_q <= dec_val;
            prev_ok_q  <= dec_ok;
        end
    end

    assign VALUE    = value_q;
    assign GLYPH_OK = glyph_ok_q;
    assign LOCKED   = (state_q == StLocked);
    assign MISMATCH = mismatch_q;
    assign ERR_CNT  = err_q;
    assign IDX      = idx_q;

endmodule

// File: tb/tb_totient_display_checker.sv
// Scoreboard bench for totient_display_checker: randomized stream against an arithmetic model.
module tb_totient_display_checker;

`ifdef TOTIENT_CHK_STICKY_FAULT_EN
    localparam bit Sticky = 1'b1;
`else
    localparam bit Sticky = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r;
    logic [6:0] seg;
    logic [3:0] value;
    logic       glyph_ok;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_cnt;
    logic [3:0] idx;

    always #5 clk = ~clk;

    totient_display_checker dut (
        .CLK_LABEL (clk),
        .R         (r),
        .SEG       (seg),
        .VALUE     (value),
        .GLYPH_OK  (glyph_ok),
        .LOCKED    (locked),
        .MISMATCH  (mismatch),
        .ERR_CNT   (err_cnt),
        .IDX       (idx)
    );

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    typedef struct {
        int value;
        int ok;
        int locked;
        int mm;
        int err;
        int idx;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: mode 0 = hunting, 1 = locked, 2 = fault
    int m_mode = 0, m_idx = 0, m_miss = 0, m_err = 0, m_pv = 0, m_pok = 0;
    int gpos = 0;

    function automatic int gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int phi(input int m);
        int c = 0;
        for (int k = 1; k <= m; k++) if (gcd(k, m) == 1) c++;
        return c;
    endfunction

    function automatic void decode(input logic [6:0] s, output int ok, output int v);
        ok = 0;
        v  = 0;
        for (int i = 0; i < 16; i++) begin
            if (seg_tab[i] == s) begin
                ok = 1;
                v  = i;
            end
        end
    endfunction

    function automatic logic [6:0] bad_glyph();
        logic [6:0] s;
        int ok, v;
        do begin
            s = 7'($urandom);
            decode(s, ok, v);
        end while (ok == 1);
        return s;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Drive one sample, advance the model, and queue the response expected after the edge.
    task automatic step(input logic [6:0] s, input logic rr);
        exp_t e;
        int ok, v, nidx, mm;
        @(negedge clk);
        seg = s;
        r   = rr;
        if (rr) begin
            m_mode = 0; m_idx = 0; m_miss = 0; m_err = 0; m_pv = 0; m_pok = 0;
            e.value = 0; e.ok = 0; e.locked = 0; e.mm = 0; e.err = 0; e.idx = 0;
        end else begin
            decode(s, ok, v);
            mm = 0;
            case (m_mode)
                0: if (m_pok == 1 && m_pv == 8 && ok == 1 && v == 1) begin
                    m_mode = 1;
                    m_idx  = 0;
                    m_miss = 0;
                end
                1: begin
                    nidx = (m_idx + 1) % 16;
                    if (ok == 1 && v == phi(nidx + 1)) begin
                        m_miss = 0;
                    end else begin
                        mm = 1;
                        if (m_err < 255) m_err++;
                        m_miss++;
                        if (m_miss == 3) m_mode = 2;
                    end
                    m_idx = nidx;
                end
                default: if (!Sticky) begin
                    m_mode = 0;
                    m_miss = 0;
                end
            endcase
            m_pok = ok;
            m_pv  = v;
            e.value  = (ok == 1) ? v : 0;
            e.ok     = ok;
            e.locked = (m_mode == 1) ? 1 : 0;
            e.mm     = mm;
            e.err    = m_err;
            e.idx    = m_idx;
        end
        q.push_back(e);
    endtask

    task automatic stream_one();
        step(seg_tab[phi(gpos + 1)], 1'b0);
        gpos = (gpos + 1) % 16;
    endtask

    task automatic corrupt_one();
        step(bad_glyph(), 1'b0);
        gpos = (gpos + 1) % 16;
    endtask

    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_value"}, int'(value), 0);
        check({tag, "_glyph_ok"}, int'(glyph_ok), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_mismatch"}, int'(mismatch), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_idx"}, int'(idx), 0);
    endtask

    task automatic lock_up();
        step(7'($urandom), 1'b1);
        gpos = $urandom_range(0, 15);
        for (int i = 0; i < 40 && m_mode != 1; i++) stream_one();
        peek();
        check("lock_up", int'(locked), 1);
    endtask

    // Monitor: every clock the DUT presents a new registered response.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                check("VALUE", int'(value), mon_e.value);
                check("GLYPH_OK", int'(glyph_ok), mon_e.ok);
                check("LOCKED", int'(locked), mon_e.locked);
                check("MISMATCH", int'(mismatch), mon_e.mm);
                check("ERR_CNT", int'(err_cnt), mon_e.err);
                check("IDX", int'(idx), mon_e.idx);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg = 7'h00;
        r   = 1'b1;
        step(7'h00, 1'b1);
        step(7'($urandom), 1'b1);
        peek();
        check_all_zero("reset");

        // Clean stream from a random phase: lock, then a long error-free run
        gpos = $urandom_range(0, 15);
        for (int i = 0; i < 90; i++) stream_one();
        peek();
        check("clean_locked", int'(locked), 1);
        check("clean_err_cnt", int'(err_cnt), 0);

        // Single invalid glyph at index 6
        for (int i = 0; i < 16 && gpos != 6; i++) stream_one();
        step(7'b1011110, 1'b0);
        gpos = 7;
        peek();
        check("single_glyph_ok", int'(glyph_ok), 0);
        check("single_mismatch", int'(mismatch), 1);
        check("single_err_cnt", int'(err_cnt), 1);
        check("single_locked", int'(locked), 1);
        check("single_idx", int'(idx), 6);
        stream_one();
        peek();
        check("single_idx_next", int'(idx), 7);
        check("single_mismatch_next", int'(mismatch), 0);
        check("single_locked_next", int'(locked), 1);

        // Three consecutive corruptions force FAULT
        lock_up();
        for (int i = 0; i < int'($urandom_range(0, 10)); i++) stream_one();
        corrupt_one();
        corrupt_one();
        corrupt_one();
        peek();
        check("triple_err_cnt", int'(err_cnt), 3);
        check("triple_locked", int'(locked), 0);
        for (int i = 0; i < 40; i++) stream_one();
        peek();
        check("after_fault_locked", int'(locked), Sticky ? 0 : 1);
        check("after_fault_err_cnt", int'(err_cnt), 3);
        step(bad_glyph(), 1'b1);
        peek();
        check_all_zero("fault_reset");

        // Saturation: lock rule satisfied again after every fault
        lock_up();
        for (int i = 0; i < 100; i++) begin
            step(bad_glyph(), 1'b0);
            step(bad_glyph(), 1'b0);
            step(bad_glyph(), 1'b0);
            step(seg_tab[8], 1'b0);
            step(seg_tab[1], 1'b0);
        end
        peek();
        check("sat_err_cnt", int'(err_cnt), Sticky ? 3 : 255);

        // Reset mid-lock at IDX = 9
        lock_up();
        for (int i = 0; i < 20 && m_idx != 9; i++) stream_one();
        peek();
        check("pre_reset_idx", int'(idx), 9);
        step(seg_tab[phi(gpos + 1)], 1'b1);
        peek();
        check_all_zero("mid_lock_reset");

        // Random soak with occasional corruption and reset
        gpos = $urandom_range(0, 15);
        for (int i = 0; i < 2000; i++) begin
            int x;
            x = $urandom_range(0, 199);
            if (x == 0) step(7'($urandom), 1'b1);
            else if (x < 25) corrupt_one();
            else stream_one();
        end
        peek();
        @(posedge clk);
        #3;
        check("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
